// File: rtl/mux_arb_reg.sv
// mux_arb_reg
//   Registered N-channel data selector with per-channel valid/ready handshakes
//   and a one-entry output register. The next channel is chosen either from
//   an explicit select (fixed mode) or by round-robin arbitration among the
//   requesting channels. Because the register accepts new data only when it
//   is empty or being drained, no word is lost or duplicated under
//   backpressure.
//
// Parameters
//   WIDTH     data width per channel (1..32)
//   CHANNELS  number of input channels (2..16)
//   SELW      derived width of select / channel-id fields
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    channel i at bits [i*WIDTH +: WIDTH]
//   in_valid   channel i offers data
//   in_ready   channel i data taken this cycle (valid & ready)
//   mode       0 = fixed select, 1 = round-robin
//   sel        channel granted in fixed mode (out-of-range grants nothing)
//   out_data   registered selected data
//   out_chan   channel id that supplied out_data
//   out_valid  output register holds data
//   out_ready  consumer accepts out_data when out_valid & out_ready
module mux_arb_reg #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    localparam int SELW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SELW-1:0]           sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SELW-1:0]           out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [WIDTH-1:0]    out_data_q,  out_data_d;
    logic [SELW-1:0]     out_chan_q,  out_chan_d;
    logic                out_valid_q, out_valid_d;
    logic [SELW-1:0]     last_q,      last_d;

    logic [CHANNELS-1:0] grant;
    logic [SELW-1:0]     gnt_idx;
    logic                gnt_any;
    logic [WIDTH-1:0]    gnt_data;
    logic                load_ok;
    int unsigned         rr_tgt;

    // The register can take a new word when empty or when its current word
    // leaves in this same cycle.
    assign load_ok = !out_valid_q || out_ready;

    // Grant selection. Round-robin visits last+1, last+2, ... modulo
    // CHANNELS; the target index is compared against every constant channel
    // number so no index can ever reach beyond CHANNELS-1.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        rr_tgt  = 0;
        if (!mode) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (sel == SELW'(i) && in_valid[i]) begin
                    grant[i] = 1'b1;
                    gnt_idx  = SELW'(i);
                    gnt_any  = 1'b1;
                end
            end
        end else begin
            for (int unsigned off = 1; off <= CHANNELS; off++) begin
                rr_tgt = 32'(last_q) + off;
                if (rr_tgt >= CHANNELS) begin
                    rr_tgt = rr_tgt - CHANNELS;
                end
                for (int unsigned j = 0; j < CHANNELS; j++) begin
                    if (!gnt_any && rr_tgt == j && in_valid[j]) begin
                        grant[j] = 1'b1;
                        gnt_idx  = SELW'(j);
                        gnt_any  = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (grant[i]) begin
                gnt_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // rst_n gating keeps every in_ready low for the whole reset interval.
    assign in_ready = grant & {CHANNELS{load_ok && rst_n}};

    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        last_d      = last_q;
        if (gnt_any && load_ok) begin
            out_data_d  = gnt_data;
            out_chan_d  = gnt_idx;
            out_valid_d = 1'b1;
            last_d      = gnt_idx;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            last_q      <= SELW'(CHANNELS - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            last_q      <= last_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_arb_reg.sv
// Directed and light random checking of mux_arb_reg with two instances:
// a 4-channel one and a 3-channel (non-power-of-two) one.
module tb_mux_arb_reg;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 4-channel instance
    logic [31:0] d4_data;
    logic [3:0]  d4_valid, d4_ready;
    logic        d4_mode;
    logic [1:0]  d4_sel;
    logic [7:0]  d4_odata;
    logic [1:0]  d4_ochan;
    logic        d4_ovalid, d4_oready;

    mux_arb_reg #(.WIDTH(8), .CHANNELS(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_data(d4_data), .in_valid(d4_valid), .in_ready(d4_ready),
        .mode(d4_mode), .sel(d4_sel),
        .out_data(d4_odata), .out_chan(d4_ochan), .out_valid(d4_ovalid),
        .out_ready(d4_oready)
    );

    // 3-channel instance
    logic [23:0] d3_data;
    logic [2:0]  d3_valid, d3_ready;
    logic        d3_mode;
    logic [1:0]  d3_sel;
    logic [7:0]  d3_odata;
    logic [1:0]  d3_ochan;
    logic        d3_ovalid, d3_oready;

    mux_arb_reg #(.WIDTH(8), .CHANNELS(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_data(d3_data), .in_valid(d3_valid), .in_ready(d3_ready),
        .mode(d3_mode), .sel(d3_sel),
        .out_data(d3_odata), .out_chan(d3_ochan), .out_valid(d3_ovalid),
        .out_ready(d3_oready)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] ch4 [4];
    logic [7:0] ch3 [3];
    logic [5:0] seq [3];

    initial begin
        logic       lok;
        logic [2:0] exp_r, hs;
        logic       prev_v, prev_r;
        logic [7:0] prev_d;
        logic [1:0] prev_c, hc;

        ch4 = '{8'h11, 8'h22, 8'h33, 8'h44};
        ch3 = '{8'h3B, 8'h5C, 8'hA5};
        seq = '{6'd0, 6'd0, 6'd0};
        d4_data = {ch4[3], ch4[2], ch4[1], ch4[0]};
        d4_valid = 4'hF; d4_mode = 1'b1; d4_sel = 2'd0; d4_oready = 1'b1;
        d3_data = {ch3[2], ch3[1], ch3[0]};
        d3_valid = 3'b000; d3_mode = 1'b0; d3_sel = 2'd0; d3_oready = 1'b1;

        // Reset state, in_ready held low even with all channels valid
        #1;
        check("rst_ovalid", d4_ovalid, 0);
        check("rst_odata", d4_odata, 0);
        check("rst_ochan", d4_ochan, 0);
        check("rst_ready", d4_ready, 0);
        check("rst3_ovalid", d3_ovalid, 0);
        tick; tick;
        rst_n = 1'b1;
        #1;
        check("rr_first_ready", d4_ready, 4'b0001);

        // Round-robin with all valid: 0,1,2,3,0,1,2,3
        for (int k = 0; k < 8; k++) begin
            tick;
            check("rr_chan", d4_ochan, k % 4);
            check("rr_data", d4_odata, ch4[k % 4]);
            check("rr_valid", d4_ovalid, 1);
            check("rr_ready", d4_ready, 4'b0001 << ((k + 1) % 4));
        end

        // Backpressure: register holds ch3 word, ch1 waits
        d4_oready = 1'b0;
        d4_valid  = 4'b0010;
        #1;
        check("bp_ready0", d4_ready, 0);
        for (int k = 0; k < 5; k++) begin
            tick;
            check("bp_data", d4_odata, 8'h44);
            check("bp_chan", d4_ochan, 3);
            check("bp_valid", d4_ovalid, 1);
            check("bp_ready", d4_ready, 0);
        end
        d4_oready = 1'b1;
        d4_data[15:8] = 8'h5A;
        #1;
        check("bp_release_ready", d4_ready, 4'b0010);
        tick;
        check("bp_load_data", d4_odata, 8'h5A);
        check("bp_load_chan", d4_ochan, 1);
        check("bp_load_valid", d4_ovalid, 1);
        d4_valid = 4'b0000;
        #1;
        check("drain_ready", d4_ready, 0);
        tick;
        check("drain_valid", d4_ovalid, 0);
        check("drain_data_hold", d4_odata, 8'h5A);
        check("drain_chan_hold", d4_ochan, 1);

        // Sparse round-robin: ch1/ch3 alternate starting after last=1
        d4_data[15:8] = ch4[1];
        d4_valid = 4'b1010;
        for (int k = 0; k < 5; k++) begin
            tick;
            check("sparse_chan", d4_ochan, (k % 2 == 0) ? 3 : 1);
            check("sparse_data", d4_odata, (k % 2 == 0) ? ch4[3] : ch4[1]);
        end
        d4_valid = 4'b0011;
        #1;
        check("wrap_ready", d4_ready, 4'b0001);
        tick;
        check("wrap_chan", d4_ochan, 0);
        check("wrap_data", d4_odata, ch4[0]);
        check("wrap_valid", d4_ovalid, 1);

        // Asynchronous reset mid-stream
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ovalid", d4_ovalid, 0);
        check("mid_rst_odata", d4_odata, 0);
        check("mid_rst_ochan", d4_ochan, 0);
        check("mid_rst_ready", d4_ready, 0);
        tick;
        check("mid_rst_hold", d4_ovalid, 0);
        rst_n = 1'b1;
        d4_valid = 4'hF;
        #1;
        check("post_rst_ready", d4_ready, 4'b0001);
        tick;
        check("post_rst_chan", d4_ochan, 0);
        check("post_rst_valid", d4_ovalid, 1);
        d4_valid = 4'b0000;

        // Fixed mode on 3 channels, including out-of-range select
        d3_mode = 1'b0; d3_sel = 2'd2; d3_valid = 3'b111; d3_oready = 1'b1;
        #1;
        check("fix_ready", d3_ready, 3'b100);
        tick;
        check("fix_data", d3_odata, 8'hA5);
        check("fix_chan", d3_ochan, 2);
        check("fix_valid", d3_ovalid, 1);
        d3_sel = 2'd3;
        #1;
        check("sel_oor_ready", d3_ready, 0);
        tick;
        check("sel_oor_valid", d3_ovalid, 0);
        check("sel_oor_data", d3_odata, 8'hA5);
        check("sel_oor_chan", d3_ochan, 2);
        d3_sel = 2'd0; d3_valid = 3'b110;
        #1;
        check("fix_notvalid_ready", d3_ready, 0);

        // Round-robin on non-power-of-two count: 0,1,2,0,1,2
        d3_mode = 1'b1; d3_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            tick;
            check("rr3_chan", d3_ochan, k % 3);
            check("rr3_data", d3_odata, ch3[k % 3]);
        end

        // Random traffic on the 3-channel instance with a register model
        for (int cyc = 0; cyc < 2000; cyc++) begin
            d3_valid  = 3'($urandom_range(0, 7));
            d3_oready = ($urandom_range(0, 3) != 0);
            d3_mode   = 1'($urandom_range(0, 1));
            d3_sel    = 2'($urandom_range(0, 3));
            d3_data   = {2'd2, seq[2], 2'd1, seq[1], 2'd0, seq[0]};
            #1;
            lok = !d3_ovalid || d3_oready;
            if (!d3_mode) begin
                exp_r = 3'b000;
                if (d3_sel < 2'd3 && lok) begin
                    if (d3_valid[d3_sel]) exp_r = 3'b001 << d3_sel;
                end
                check("rnd_fix_ready", d3_ready, exp_r);
            end else begin
                check("rnd_rr_subset", d3_ready & ~d3_valid, 0);
                check("rnd_rr_any", |d3_ready, lok && (|d3_valid));
            end
            check("rnd_onehot", $onehot0(d3_ready), 1);
            hs     = d3_valid & d3_ready;
            prev_v = d3_ovalid;
            prev_r = d3_oready;
            prev_d = d3_odata;
            prev_c = d3_ochan;
            hc     = 2'd0;
            for (int i = 2; i >= 0; i--) if (hs[i]) hc = 2'(i);
            tick;
            if (hs != 0) begin
                check("rnd_load_chan", d3_ochan, hc);
                check("rnd_load_data", d3_odata, {hc, seq[hc]});
                check("rnd_load_valid", d3_ovalid, 1);
                seq[hc] = seq[hc] + 6'd1;
            end else if (prev_v && prev_r) begin
                check("rnd_drain_valid", d3_ovalid, 0);
                check("rnd_drain_data", d3_odata, prev_d);
            end else begin
                check("rnd_hold_valid", d3_ovalid, prev_v);
                check("rnd_hold_data", d3_odata, prev_d);
                check("rnd_hold_chan", d3_ochan, prev_c);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
